// File: rtl/manhattan_update_array_if.sv
// Handshake and data bundle between the back-prop error stage, the Manhattan update
// array and the weight register file. Vectors carry NUM_CH tagged words, ch0 in LSBs.
interface manhattan_update_array_if #(
  parameter int BIT_WIDTH  = 32,
  parameter int EXTRA_BITS = 2,
  parameter int NUM_CH     = 4
);
  localparam int W = BIT_WIDTH + EXTRA_BITS;

  logic                start;
  logic [W-1:0]        eta;
  logic [NUM_CH*W-1:0] Differentiated_Error;
  logic [NUM_CH*W-1:0] Old_Weights;
  logic                busy;
  logic                done;
  logic [NUM_CH*W-1:0] Updated_Weights;
  logic [W-1:0]        New_eta;
  logic                nan_flag;

  modport master (
    output start, eta, Differentiated_Error, Old_Weights,
    input  busy, done, Updated_Weights, New_eta, nan_flag
  );

  modport slave (
    input  start, eta, Differentiated_Error, Old_Weights,
    output busy, done, Updated_Weights, New_eta, nan_flag
  );
endinterface

// File: rtl/manhattan_update_array.sv
// Sequential Manhattan-rule weight update: w -= |eta|*sign(dE) for NUM_CH tagged IEEE
// single weights through one pipelined adder, followed by an optional eta decay.
module manhattan_update_array #(
  parameter int BIT_WIDTH   = 32,
  parameter int EXTRA_BITS  = 2,
  parameter int NUM_CH      = 4,
  parameter int ADD_LATENCY = 3,
  parameter int ETA_SHIFT   = 1
) (
  input logic clk,
  input logic rst,
  manhattan_update_array_if.slave bus
);
  localparam int W  = BIT_WIDTH + EXTRA_BITS;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int L  = ADD_LATENCY;
  localparam logic [1:0] TAG_ZERO = 2'b00, TAG_NORM = 2'b01, TAG_INF = 2'b10, TAG_NAN = 2'b11;
  localparam logic [L-1:0] UP_MASK = ~(L'(1) << (L - 1));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  // Tagged IEEE single add, round-to-nearest-even, denormals flushed to zero.
  function automatic logic [33:0] fp_add(input logic [33:0] a, input logic [33:0] b);
    logic        a_zero, b_zero, a_inf, b_inf, swap, sub, sgn, rnd;
    logic [30:0] big, sml;
    logic [26:0] mb, ms, mask;
    logic [27:0] sum;
    logic [24:0] m;
    int          e, d, lz;
    fp_add = '0;
    a_zero = (a[33:32] == TAG_ZERO) || (a[30:23] == 8'd0);
    b_zero = (b[33:32] == TAG_ZERO) || (b[30:23] == 8'd0);
    a_inf  = (a[33:32] == TAG_INF);
    b_inf  = (b[33:32] == TAG_INF);
    if (a[33:32] == TAG_NAN || b[33:32] == TAG_NAN || (a_inf && b_inf && a[31] != b[31]))
      fp_add = {TAG_NAN, 32'h7FC00000};
    else if (a_inf)           fp_add = {TAG_INF, a[31], 8'hFF, 23'd0};
    else if (b_inf)           fp_add = {TAG_INF, b[31], 8'hFF, 23'd0};
    else if (a_zero && b_zero) fp_add = '0;
    else if (a_zero)          fp_add = {TAG_NORM, b[31:0]};
    else if (b_zero)          fp_add = {TAG_NORM, a[31:0]};
    else begin
      swap = b[30:0] > a[30:0];
      big  = swap ? b[30:0] : a[30:0];
      sml  = swap ? a[30:0] : b[30:0];
      sgn  = swap ? b[31] : a[31];
      sub  = a[31] ^ b[31];
      e    = int'(big[30:23]);
      d    = int'(big[30:23]) - int'(sml[30:23]);
      mb   = {1'b1, big[22:0], 3'b000};
      ms   = {1'b1, sml[22:0], 3'b000};
      if (d > 26) ms = 27'd1;
      else if (d > 0) begin
        mask = (27'd1 << d) - 27'd1;
        ms   = (ms >> d) | {26'd0, |(ms & mask)};
      end
      sum = sub ? ({1'b0, mb} - {1'b0, ms}) : ({1'b0, mb} + {1'b0, ms});
      if (sum != 28'd0) begin
        if (sum[27]) begin
          sum = (sum >> 1) | {27'd0, sum[0]};
          e   = e + 1;
        end else begin
          lz = 0;
          for (int i = 0; i < 27; i++) if (sum[i]) lz = 26 - i;
          sum = sum << lz;
          e   = e - lz;
        end
        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        m   = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (m[24]) begin
          m = m >> 1;
          e = e + 1;
        end
        if (e >= 255)   fp_add = {TAG_INF, sgn, 8'hFF, 23'd0};
        else if (e > 0) fp_add = {TAG_NORM, sgn, e[7:0], m[22:0]};
      end
    end
  endfunction

  function automatic logic [33:0] eta_decay(input logic [33:0] e, input logic used);
    eta_decay = {e[33:32], 1'b0, e[30:0]};
    if (used) begin
      if (e[33])
        eta_decay = e;
      else if (e[33:32] == TAG_ZERO || e[30:23] <= 8'(ETA_SHIFT))
        eta_decay = '0;
      else
        eta_decay = {TAG_NORM, 1'b0, e[30:23] - 8'(ETA_SHIFT), e[22:0]};
    end
  endfunction

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_eta;
  logic [1:0]    r_de_tag [NUM_CH];
  logic          r_de_sgn [NUM_CH];
  logic [W-1:0]  r_w_old  [NUM_CH];
  logic [W-1:0]  r_slot   [NUM_CH];
  logic [W-1:0]  r_upd    [NUM_CH];
  logic [W-1:0]  w_slot_nxt [NUM_CH];
  logic [IW-1:0] r_ch_idx;
  logic          r_used, r_nan, r_nan_flag;
  logic [W-1:0]  r_new_eta;
  logic [W-1:0]  r_res_p [L];
  logic [IW-1:0] r_idx_p [L];
  logic [L-1:0]  r_vld_p;
  logic          w_issue, w_last, w_bypass;
  logic [W-1:0]  w_opb, w_issue_res;

  // Issue stage: bypassed channels still ride the pipe so latency never varies.
  assign w_issue     = (r_state == ISSUE);
  assign w_last      = (r_ch_idx == IW'(NUM_CH - 1));
  assign w_bypass    = (r_de_tag[r_ch_idx] == TAG_ZERO) || (r_de_tag[r_ch_idx] == TAG_NAN);
  assign w_opb       = {TAG_NORM, ~r_de_sgn[r_ch_idx], r_eta[30:0]};
  assign w_issue_res = w_bypass ? r_w_old[r_ch_idx] : fp_add(r_w_old[r_ch_idx], w_opb);

  // Retire stage: the result leaving the pipe on the FINISH edge is folded in directly.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      w_slot_nxt[c] = (r_vld_p[L-1] && r_idx_p[L-1] == IW'(c)) ? r_res_p[L-1] : r_slot[c];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ISSUE;
      ISSUE:   if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if ((r_vld_p & UP_MASK) == '0) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ch_idx   <= '0;
      r_vld_p    <= '0;
      r_used     <= 1'b0;
      r_nan      <= 1'b0;
      r_nan_flag <= 1'b0;
      r_new_eta  <= '0;
      for (int c = 0; c < NUM_CH; c++) r_upd[c] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vld_p[0] <= w_issue;
      for (int s = 1; s < L; s++) r_vld_p[s] <= r_vld_p[s-1];
      if (r_state == IDLE && bus.start) begin
        r_ch_idx <= '0;
        r_used   <= 1'b0;
        r_nan    <= 1'b0;
      end
      if (w_issue) begin
        if (!w_last) r_ch_idx <= r_ch_idx + 1'b1;
        r_used <= r_used | ~w_bypass;
        r_nan  <= r_nan | (r_de_tag[r_ch_idx] == TAG_NAN);
      end
      if (r_state == DRAIN && w_state_nxt == FINISH) begin
        for (int c = 0; c < NUM_CH; c++) r_upd[c] <= w_slot_nxt[c];
        r_nan_flag <= r_nan;
        r_new_eta  <= eta_decay(r_eta, r_used);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.start) begin
      r_eta <= bus.eta;
      for (int c = 0; c < NUM_CH; c++) begin
        r_de_tag[c] <= bus.Differentiated_Error[c*W+W-1 -: 2];
        r_de_sgn[c] <= bus.Differentiated_Error[c*W+31];
        r_w_old[c]  <= bus.Old_Weights[c*W +: W];
      end
    end
    r_res_p[0] <= w_issue_res;
    r_idx_p[0] <= r_ch_idx;
    for (int s = 1; s < L; s++) begin
      r_res_p[s] <= r_res_p[s-1];
      r_idx_p[s] <= r_idx_p[s-1];
    end
    if (r_vld_p[L-1]) r_slot[r_idx_p[L-1]] <= r_res_p[L-1];
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == FINISH);
  assign bus.New_eta  = r_new_eta;
  assign bus.nan_flag = r_nan_flag;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.Updated_Weights[g*W +: W] = r_upd[g];
  end
endmodule

// File: tb/tb_manhattan_update_array.sv
// Directed bench for manhattan_update_array: a 1-channel and a 4-channel instance
// driven with hand-computed IEEE single vectors.
module tb_manhattan_update_array;
  localparam int W = 34;
  localparam int L = 3;
  localparam logic [W-1:0] ETA1  = {2'b01, 32'h3A83126F};
  localparam logic [W-1:0] NETA1 = {2'b01, 32'h3A03126F};
  localparam logic [W-1:0] DEP   = {2'b01, 32'h3F7D70A4};
  localparam logic [W-1:0] DEN   = {2'b01, 32'hBF7D70A4};
  localparam logic [W-1:0] DNAN  = {2'b11, 32'h7FC00000};
  localparam logic [W-1:0] INF   = {2'b10, 32'h7F800000};
  localparam logic [W-1:0] W22   = {2'b01, 32'h3E6147AE};
  localparam logic [W-1:0] R219  = {2'b01, 32'h3E604189};
  localparam logic [W-1:0] R221  = {2'b01, 32'h3E624DD3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp, n_bad;

  always #5 clk = ~clk;

  manhattan_update_array_if #(.BIT_WIDTH(32), .EXTRA_BITS(2), .NUM_CH(1)) b1();
  manhattan_update_array_if #(.BIT_WIDTH(32), .EXTRA_BITS(2), .NUM_CH(4)) b4();

  manhattan_update_array #(.BIT_WIDTH(32), .EXTRA_BITS(2), .NUM_CH(1), .ADD_LATENCY(L), .ETA_SHIFT(1))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  manhattan_update_array #(.BIT_WIDTH(32), .EXTRA_BITS(2), .NUM_CH(4), .ADD_LATENCY(L), .ETA_SHIFT(1))
    u4 (.clk(clk), .rst(rst), .bus(b4));

  task automatic run1(input logic [W-1:0] eta, input logic [W-1:0] de, input logic [W-1:0] w,
                      output int lat);
    @(posedge clk); #1;
    b1.start = 1'b1; b1.eta = eta; b1.Differentiated_Error = de; b1.Old_Weights = w;
    @(posedge clk); #1;
    b1.start = 1'b0; b1.eta = ~eta; b1.Differentiated_Error = ~de; b1.Old_Weights = ~w;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (b1.done) lat = k;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic run4(input logic [W-1:0] eta, input logic [4*W-1:0] de, input logic [4*W-1:0] w,
                      output int lat);
    @(posedge clk); #1;
    b4.start = 1'b1; b4.eta = eta; b4.Differentiated_Error = de; b4.Old_Weights = w;
    @(posedge clk); #1;
    b4.start = 1'b0; b4.eta = ~eta; b4.Differentiated_Error = ~de; b4.Old_Weights = ~w;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (b4.done) lat = k;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin n_bad++; $display("FAIL reset_ctl1: got busy %b done %b want 0 0", b1.busy, b1.done); end
    n_cmp++; if (b4.Updated_Weights !== '0 || b4.New_eta !== '0 || b4.nan_flag !== 1'b0) begin n_bad++; $display("FAIL reset_out4: got %h %h %b want zeros", b4.Updated_Weights, b4.New_eta, b4.nan_flag); end
    @(posedge clk); #1;
    b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (b4.busy !== 1'b0) begin n_bad++; $display("FAIL start_with_rst: got busy %b want 0", b4.busy); end
  endtask

  task automatic test_single;
    int lat;
    run1(ETA1, DEP, W22, lat);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL single_latency: got %0d want 5", lat); end
    n_cmp++; if (b1.Updated_Weights !== R219) begin n_bad++; $display("FAIL single_w: got %h want %h", b1.Updated_Weights, R219); end
    n_cmp++; if (b1.New_eta !== NETA1) begin n_bad++; $display("FAIL single_eta: got %h want %h", b1.New_eta, NETA1); end
    n_cmp++; if (b1.nan_flag !== 1'b0) begin n_bad++; $display("FAIL single_nan: got %b want 0", b1.nan_flag); end
    @(posedge clk); #1;
    n_cmp++; if (b1.done !== 1'b0 || b1.busy !== 1'b0 || b1.Updated_Weights !== R219) begin n_bad++; $display("FAIL single_after: got done %b busy %b w %h want 0 0 %h", b1.done, b1.busy, b1.Updated_Weights, R219); end
  endtask

  task automatic test_sign;
    int lat;
    run1(ETA1, DEN, W22, lat);
    n_cmp++; if (b1.Updated_Weights !== R221) begin n_bad++; $display("FAIL neg_de_w: got %h want %h", b1.Updated_Weights, R221); end
    run1({2'b01, 32'hB8D1B717}, DEP, W22, lat);
    n_cmp++; if (b1.Updated_Weights !== {2'b01, 32'h3E612D77}) begin n_bad++; $display("FAIL neg_eta_w: got %h want %h", b1.Updated_Weights, {2'b01, 32'h3E612D77}); end
    n_cmp++; if (b1.New_eta !== {2'b01, 32'h3851B717}) begin n_bad++; $display("FAIL neg_eta_decay: got %h want %h", b1.New_eta, {2'b01, 32'h3851B717}); end
    run1({2'b01, 32'h38D1B717}, DEP, W22, lat);
    n_cmp++; if (b1.Updated_Weights !== {2'b01, 32'h3E612D77}) begin n_bad++; $display("FAIL pos_eta_w: got %h want %h", b1.Updated_Weights, {2'b01, 32'h3E612D77}); end
  endtask

  task automatic test_multi;
    int lat;
    run4(ETA1, {DNAN, 34'h0, DEN, DEP}, {4{W22}}, lat);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL multi_latency: got %0d want 8", lat); end
    n_cmp++; if (b4.Updated_Weights !== {W22, W22, R221, R219}) begin n_bad++; $display("FAIL multi_w: got %h want %h", b4.Updated_Weights, {W22, W22, R221, R219}); end
    n_cmp++; if (b4.nan_flag !== 1'b1) begin n_bad++; $display("FAIL multi_nan: got %b want 1", b4.nan_flag); end
    n_cmp++; if (b4.New_eta !== NETA1) begin n_bad++; $display("FAIL multi_eta: got %h want %h", b4.New_eta, NETA1); end
  endtask

  task automatic test_bypass;
    int lat;
    logic [4*W-1:0] w;
    w = {INF, 34'h0, {2'b01, 32'h3F800000}, W22};
    run4({2'b01, 32'hBA83126F}, '0, w, lat);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL bypass_latency: got %0d want 8", lat); end
    n_cmp++; if (b4.Updated_Weights !== w) begin n_bad++; $display("FAIL bypass_w: got %h want %h", b4.Updated_Weights, w); end
    n_cmp++; if (b4.New_eta !== ETA1) begin n_bad++; $display("FAIL bypass_eta_abs: got %h want %h", b4.New_eta, ETA1); end
    n_cmp++; if (b4.nan_flag !== 1'b0) begin n_bad++; $display("FAIL bypass_nan: got %b want 0", b4.nan_flag); end
    run4({2'b01, 32'h00800000}, {34'h0, 34'h0, 34'h0, DEP}, {4{W22}}, lat);
    n_cmp++; if (b4.New_eta !== 34'h0) begin n_bad++; $display("FAIL eta_underflow: got %h want 0", b4.New_eta); end
    n_cmp++; if (b4.Updated_Weights !== {4{W22}}) begin n_bad++; $display("FAIL tiny_eta_w: got %h want %h", b4.Updated_Weights, {4{W22}}); end
  endtask

  task automatic test_mid_reset;
    int lat, ndone;
    @(posedge clk); #1;
    b4.start = 1'b1; b4.eta = ETA1; b4.Differentiated_Error = {4{DEN}}; b4.Old_Weights = {4{W22}};
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (b4.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", b4.busy); end
    n_cmp++; if (b4.Updated_Weights !== '0 || b4.New_eta !== '0 || b4.nan_flag !== 1'b0) begin n_bad++; $display("FAIL midrst_out: got %h %h %b want zeros", b4.Updated_Weights, b4.New_eta, b4.nan_flag); end
    ndone = 0;
    for (int k = 0; k < 15; k++) begin @(negedge clk); if (b4.done) ndone++; end
    n_cmp++; if (ndone !== 0) begin n_bad++; $display("FAIL midrst_done: got %0d dones want 0", ndone); end
    run4(ETA1, {DNAN, 34'h0, DEN, DEP}, {4{W22}}, lat);
    n_cmp++; if (lat !== 8 || b4.Updated_Weights !== {W22, W22, R221, R219}) begin n_bad++; $display("FAIL midrst_fresh: got lat %0d w %h want 8 %h", lat, b4.Updated_Weights, {W22, W22, R221, R219}); end
  endtask

  task automatic test_back_to_back;
    int lat, ndone;
    @(posedge clk); #1;
    b4.start = 1'b1; b4.eta = ETA1; b4.Differentiated_Error = {DNAN, 34'h0, DEN, DEP}; b4.Old_Weights = {4{W22}};
    @(posedge clk); #1;
    b4.start = 1'b0;
    @(posedge clk); #1;
    b4.start = 1'b1; b4.Differentiated_Error = {4{DEN}};
    @(posedge clk); #1;
    b4.start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin @(negedge clk); if (b4.done) ndone++; end
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL repulse_done: got %0d dones want 1", ndone); end
    n_cmp++; if (b4.Updated_Weights !== {W22, W22, R221, R219}) begin n_bad++; $display("FAIL repulse_w: got %h want %h", b4.Updated_Weights, {W22, W22, R221, R219}); end
    run4(ETA1, {DEP, DEN, INF, DEP}, {ETA1, W22, 34'h0, INF}, lat);
    n_cmp++; if (b4.Updated_Weights !== {34'h0, R221, {2'b01, 32'hBA83126F}, INF}) begin n_bad++; $display("FAIL b2b_a_w: got %h want %h", b4.Updated_Weights, {34'h0, R221, {2'b01, 32'hBA83126F}, INF}); end
    n_cmp++; if (b4.New_eta !== NETA1 || b4.nan_flag !== 1'b0) begin n_bad++; $display("FAIL b2b_a_eta: got %h %b want %h 0", b4.New_eta, b4.nan_flag, NETA1); end
    run4(ETA1, {4{DEN}}, {4{W22}}, lat);
    n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL b2b_b_latency: got %0d want 8", lat); end
    n_cmp++; if (b4.Updated_Weights !== {4{R221}}) begin n_bad++; $display("FAIL b2b_b_w: got %h want %h", b4.Updated_Weights, {4{R221}}); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    b1.start = 1'b0; b1.eta = '0; b1.Differentiated_Error = '0; b1.Old_Weights = '0;
    b4.start = 1'b0; b4.eta = '0; b4.Differentiated_Error = '0; b4.Old_Weights = '0;
    test_reset;
    test_single;
    test_sign;
    test_multi;
    test_bypass;
    test_mid_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
